// File: rtl/snake_pkg.sv
// Shared codes for the GreedySnake direction/step controller.
package snake_pkg;

    localparam logic [1:0] FORWARD_X_UP   = 2'b00;
    localparam logic [1:0] FORWARD_X_DOWN = 2'b01;
    localparam logic [1:0] FORWARD_Y_UP   = 2'b10;
    localparam logic [1:0] FORWARD_Y_DOWN = 2'b11;

    localparam logic [3:0] MODE_RESET_SNAKE = 4'd0;
    localparam logic [3:0] MODE_UPDATE_POS  = 4'd1;
    localparam logic [3:0] MODE_PAUSED      = 4'd2;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // A zero-length step would never reach terminal count, so floor it at one cycle.
    function automatic logic [31:0] step_period(input logic [31:0] base, input logic [31:0] shamt);
        logic [31:0] p;
        p = base >> shamt;
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Key/step bundle between the board keys and the snake update logic.
interface snake_dir_ctrl_if #(
    parameter int unsigned SPEED_W = 2,
    parameter int unsigned QL_W    = 2
);
    logic               key_x_up;
    logic               key_x_down;
    logic               key_y_up;
    logic               key_y_down;
    logic               key_pause;
    logic [SPEED_W-1:0] speed;
    logic               en;
    logic [1:0]         forward;
    logic [3:0]         mode;
    logic [QL_W-1:0]    queue_level;

    modport master (
        output key_x_up, key_x_down, key_y_up, key_y_down, key_pause, speed,
        input  en, forward, mode, queue_level
    );

    modport slave (
        input  key_x_up, key_x_down, key_y_up, key_y_down, key_pause, speed,
        output en, forward, mode, queue_level
    );
endinterface

// File: rtl/key_debounce.sv
// Synchronises one raw key and accepts a new level only after DEBOUNCE_CNT stable cycles.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 270_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

    logic             sync_0;
    logic             sync_1;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_0  <= 1'b0;
            sync_1  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_0  <= key;
            sync_1  <= sync_0;
            level_d <= level;
            press   <= level & ~level_d;
            if (sync_1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
                level <= sync_1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction/step controller: debounced keys, turn queue and speed-selectable step strobe.
//   state    | meaning
//   ST_RESET | one cycle after reset, snake re-initialised downstream
//   ST_RUN   | step counter running, turns accepted
//   ST_PAUSE | counter and queue frozen until the next pause press
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_BASE_CNT = 27_000_000,
    parameter int unsigned SPEED_W       = 2,
    parameter int unsigned DEBOUNCE_CNT  = 270_000,
    parameter int unsigned QUEUE_DEPTH   = 2
) (
    input logic             clk,
    input logic             rst,
    snake_dir_ctrl_if.slave bus
);
    localparam int unsigned QL_W  = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);

    logic [4:0] key_raw;
    logic [4:0] key_level;
    logic [4:0] key_press;
    logic [4:0] press;

    // Bit index equals the forward code for the four direction keys.
    assign key_raw = {bus.key_pause, bus.key_y_down, bus.key_y_up, bus.key_x_down, bus.key_x_up};

    for (genvar i = 0; i < 5; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key (
            .clk   (clk),
            .rst   (rst),
            .key   (key_raw[i]),
            .level (key_level[i]),
            .press (key_press[i])
        );
    end

    assign press = key_press & key_level;

    state_t           state, state_nx;
    logic [31:0]      cnt, cnt_nx;
    logic [31:0]      period, period_nx;
    logic             en_q, en_nx;
    logic [1:0]       fwd_q, fwd_nx;
    logic [3:0]       mode_q, mode_nx;

    logic [1:0]       q_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, tail_ptr;
    logic [QL_W-1:0]  q_level;
    logic             enq, deq;
    logic             sel_valid;
    logic [1:0]       sel_dir;
    logic [1:0]       ref_dir;

    assign tail_ptr = wr_ptr - 1'b1;
    assign ref_dir  = (q_level == '0) ? fwd_q : q_mem[tail_ptr];

    always_comb begin
        sel_valid = 1'b0;
        sel_dir   = FORWARD_X_UP;
        if (press[FORWARD_Y_UP]) begin
            sel_valid = 1'b1;
            sel_dir   = FORWARD_Y_UP;
        end else if (press[FORWARD_Y_DOWN]) begin
            sel_valid = 1'b1;
            sel_dir   = FORWARD_Y_DOWN;
        end else if (press[FORWARD_X_UP]) begin
            sel_valid = 1'b1;
            sel_dir   = FORWARD_X_UP;
        end else if (press[FORWARD_X_DOWN]) begin
            sel_valid = 1'b1;
            sel_dir   = FORWARD_X_DOWN;
        end
        // Only perpendicular turns are meaningful; same-axis presses would reverse into the body.
        enq = sel_valid && (state == ST_RUN) && (q_level != QL_W'(QUEUE_DEPTH))
              && (sel_dir[1] != ref_dir[1]);
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        period_nx = period;
        en_nx     = 1'b0;
        fwd_nx    = fwd_q;
        deq       = 1'b0;
        case (state)
            ST_RESET: begin
                state_nx = ST_RUN;
                cnt_nx   = '0;
            end
            ST_RUN: begin
                if (cnt == period - 32'd1) begin
                    cnt_nx    = '0;
                    en_nx     = 1'b1;
                    period_nx = step_period(TICK_BASE_CNT, 32'(bus.speed));
                    if (q_level != '0) begin
                        deq    = 1'b1;
                        fwd_nx = q_mem[rd_ptr];
                    end
                    if (press[4]) state_nx = ST_PAUSE;
                end else if (press[4]) begin
                    state_nx = ST_PAUSE;
                end else begin
                    cnt_nx = cnt + 32'd1;
                end
            end
            ST_PAUSE: begin
                if (press[4]) state_nx = ST_RUN;
            end
            default: state_nx = ST_RESET;
        endcase

        case (state_nx)
            ST_RUN:   mode_nx = MODE_UPDATE_POS;
            ST_PAUSE: mode_nx = MODE_PAUSED;
            default:  mode_nx = MODE_RESET_SNAKE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_RESET;
            cnt     <= '0;
            period  <= step_period(TICK_BASE_CNT, 32'd0);
            en_q    <= 1'b0;
            fwd_q   <= FORWARD_X_UP;
            mode_q  <= MODE_RESET_SNAKE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_level <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            period <= period_nx;
            en_q   <= en_nx;
            fwd_q  <= fwd_nx;
            mode_q <= mode_nx;
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   q_level <= q_level + 1'b1;
                2'b01:   q_level <= q_level - 1'b1;
                default: q_level <= q_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) q_mem[wr_ptr] <= sel_dir;
    end

    assign bus.en          = en_q;
    assign bus.forward     = fwd_q;
    assign bus.mode        = mode_q;
    assign bus.queue_level = q_level;
endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Parametrised direction/step controller for the GreedySnake game, successor to the fixed 1 s key controller. Debounces raw direction and pause keys and buffers turn commands in a small queue, so quick double-turns are not lost. Emits a one-cycle step strobe at a selectable speed, with the direction for that step. Sits between the board keys and the snake position/BSRAM update logic; `en`/`forward`/`mode` keep their existing meaning for downstream.

## Interface
Parameters:
- `TICK_BASE_CNT`, 27_000_000: clock cycles per step at speed 0 (1 s at 27 MHz).
- `SPEED_W`, 2: width of `speed`; step period = `TICK_BASE_CNT >> speed`.
- `DEBOUNCE_CNT`, 270_000: consecutive stable samples needed to accept a key level (10 ms).
- `QUEUE_DEPTH`, 2: turn-queue entries, power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `key_x_up`, `key_x_down`, `key_y_up`, `key_y_down`  in  1 each  raw active-high direction keys, asynchronous.
- `key_pause`  in  1  raw active-high pause/resume key, asynchronous.
- `speed`  in  SPEED_W  speed select, sampled only at step boundaries.
- `en`  out  1  one-cycle step strobe.
- `forward`  out  2  direction for the current step: X_UP=00, X_DOWN=01, Y_UP=10, Y_DOWN=11.
- `mode`  out  4  0=RESET_SNAKE, 1=UPDATE_POS, 2=PAUSED.
- `queue_level`  out  $clog2(QUEUE_DEPTH)+1  pending turns.

## Operation
- Reset (`rst`=0 at a clk edge) sets `en`=0, `forward`=00, `mode`=0, `queue_level`=0. It also clears the queue, the step counter and the debouncers (debounced levels=0), and forces state RESET.
- Debounce, per key:
  - 2-FF synchroniser, then a counter.
  - The debounced level changes only after DEBOUNCE_CNT consecutive cycles of the new synchronised value.
  - A 0→1 transition of the debounced level gives a one-cycle press pulse.
- Turn acceptance:
  - Reference direction is the queue tail, or `forward` if the queue is empty.
  - A press on the same axis as the reference (same direction or reversal) is discarded.
  - A press is also discarded when the queue is full or state ≠ RUN.
  - Simultaneous presses in one cycle: priority y_up > y_down > x_up > x_down. At most one is enqueued per cycle.
- State machine (RESET, RUN, PAUSE):
  - RESET: one cycle, `mode`=0 → RUN.
  - RUN: `mode`=1. The counter increments. At count == period−1 the counter clears, `en`=1, and `forward` takes the dequeued head (unchanged if the queue is empty). `speed` is latched into period at this same edge. A pause press → PAUSE.
  - PAUSE: `mode`=2. Counter holds its value, `en`=0, queue retained. A pause press → RUN, and the count resumes from the held value.
- Enqueue and dequeue in the same cycle are both performed; `queue_level` is unchanged.
- Period arithmetic is 32-bit unsigned. A period of 0 is clamped to 1.

## Timing
- All outputs are registered. `forward` and `en` change on the same edge.
- Key press to press pulse: 2 sync + DEBOUNCE_CNT + 1 cycles.
- Press pulse to `queue_level` increment: 1 cycle.
- First `en` comes TICK_BASE_CNT cycles after the RUN entry edge, with `speed` as latched at reset (speed 0).
- A new `speed` takes effect from the period following the next `en`.
- Pause and resume: a pulse changes `mode` one cycle after the press pulse. A pause press coincident with the terminal count: the step (`en`) completes first, then PAUSE.
- Releasing reset mid-count: the counter restarts from 0 and no `en` is issued in the reset cycle.

## Structure
- Package `snake_pkg`: forward codes (FORWARD_X_UP..Y_DOWN), mode codes (MODE_RESET_SNAKE, MODE_UPDATE_POS, MODE_PAUSED), state enum.
- Sub-module `key_debounce` (parameter DEBOUNCE_CNT; outputs level and press pulse), instantiated five times.
- Queue, speed/period logic and FSM stay in `snake_dir_ctrl`.

## Test plan
Parameters: TICK_BASE_CNT=16, DEBOUNCE_CNT=4, QUEUE_DEPTH=2.
- Reset and idle: hold `rst`=0 for 3 cycles, then release with no keys → `en` pulses at cycles 16, 32, 48 after RUN entry; `forward`=00; `mode`=1.
- Debounce: `key_y_up` glitch high for 3 cycles → no enqueue. Held for 10 cycles → `queue_level`=1, and at the next `en` `forward`=10.
- Queue burst: starting at `forward`=00, press y_up then x_down within one period → next `en` gives 10, the following `en` gives 01, then `queue_level`=0. A third valid press while the queue is full is dropped.
- Reversal rejection: `forward`=10, press y_down → `queue_level` stays 0, `forward` remains 10.
- Pause: pause press at count 7 → `mode`=2, no `en` for 100 cycles. Resume → next `en` 9 cycles after the resume edge.
- Speed: set `speed`=2 mid-period → the current period stays 16, subsequent `en` spacing is 4. Reset mid-period → outputs return to reset values.
